// File: rtl/elevator_call_panel_if.sv
// Target-offer handshake between the call panel and the elevator controller.
//   req_valid : panel offers req_floor as the next target
//   req_ready : elevator accepts the offered target
//   req_floor : offered target floor, binary
// master = call panel, slave = elevator controller.
interface elevator_call_panel_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_floor;

  modport master (output req_valid, output req_floor, input req_ready);
  modport slave  (input req_valid, input req_floor, output req_ready);
endinterface

// File: rtl/elevator_call_panel.sv
// Elevator call panel: latches hall-call buttons into pending lamps, picks the
// next target floor with a sweep (elevator) policy and offers it to the car
// controller over a valid/ready handshake.
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous, active-low
//   btn          level call buttons, bit i = floor i
//   car_floor    current car floor, binary 0-4
//   car_stopped  car stopped at car_floor with doors open
//   req          target handshake (master side: req_valid, req_floor out; req_ready in)
//   pending      latched outstanding calls (lamp drive)
//   dir_up       current sweep direction, 1 = up
//   timeout      one-cycle watchdog pulse
//
// Build option: define REQ_TIMEOUT_EN to add the WAIT_ARRIVE watchdog
// (TIMEOUT_CYCLES clocks). Without it, timeout is tied low and the panel
// waits for arrival indefinitely.
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | no target outstanding; picks one as soon as a call pends
// OFFER       | req_valid high, waiting for req_ready
// WAIT_ARRIVE | target accepted, waiting for the car to stop there
module elevator_call_panel #(
  parameter int NUM_FLOORS     = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] btn,
  input  logic [2:0]            car_floor,
  input  logic                  car_stopped,
  elevator_call_panel_if.master req,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  timeout
);

  typedef enum logic [1:0] {IDLE, OFFER, WAIT_ARRIVE} state_t;

  state_t                state, state_nxt;
  logic [NUM_FLOORS-1:0] btn_q, btn_rise, clr_mask;
  logic                  btn_armed;
  logic                  here_hit, above_hit, below_hit;
  logic [2:0]            above_idx, below_idx;
  logic [2:0]            sel_floor, req_floor_r;
  logic                  sel_dir_up;
  logic                  tgt_pending, arrived, offer_take;
  logic                  wd_done;

  // btn_armed stays low for the first clock after reset so buttons held
  // through reset only load btn_q and never register as new presses.
  assign btn_rise = btn_armed ? (btn & ~btn_q) : '0;

  // Per-floor decode: stop-clear mask, and pending calls at / above / below
  // the car. Ascending scan: first hit above is the lowest, last hit below
  // is the highest.
  always_comb begin
    clr_mask    = '0;
    here_hit    = 1'b0;
    above_hit   = 1'b0;
    below_hit   = 1'b0;
    above_idx   = '0;
    below_idx   = '0;
    tgt_pending = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (car_stopped && car_floor == i[2:0]) clr_mask[i] = 1'b1;
      if (pending[i] && car_floor == i[2:0]) here_hit = 1'b1;
      if (pending[i] && req_floor_r == i[2:0]) tgt_pending = 1'b1;
      if (pending[i] && i[2:0] > car_floor && !above_hit) begin
        above_hit = 1'b1;
        above_idx = i[2:0];
      end
      if (pending[i] && i[2:0] < car_floor) begin
        below_hit = 1'b1;
        below_idx = i[2:0];
      end
    end
  end

  // Target selection; reverses the sweep when nothing lies ahead.
  always_comb begin
    sel_floor  = req_floor_r;
    sel_dir_up = dir_up;
    if (here_hit) begin
      sel_floor = car_floor;
    end else if (dir_up) begin
      if (above_hit) begin
        sel_floor = above_idx;
      end else begin
        sel_dir_up = 1'b0;
        sel_floor  = below_idx;
      end
    end else begin
      if (below_hit) begin
        sel_floor = below_idx;
      end else begin
        sel_dir_up = 1'b1;
        sel_floor  = above_idx;
      end
    end
  end

  assign arrived    = car_stopped && (car_floor == req_floor_r);
  assign offer_take = (state == OFFER) && tgt_pending && req.req_ready;

  // Call latches; a stop clears its floor even if pressed in the same clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q     <= '0;
      btn_armed <= 1'b0;
      pending   <= '0;
    end else begin
      btn_q     <= btn;
      btn_armed <= 1'b1;
      pending   <= (pending | btn_rise) & ~clr_mask;
    end
  end

  // Target and sweep direction are only updated when leaving IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_floor_r <= '0;
      dir_up      <= 1'b1;
    end else if (state == IDLE && pending != '0) begin
      req_floor_r <= sel_floor;
      dir_up      <= sel_dir_up;
    end
  end

`ifdef REQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] watchdog;

  // Down-counter loaded on acceptance; terminal count on the
  // TIMEOUT_CYCLES-th clock spent in WAIT_ARRIVE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      watchdog <= '0;
    end else if (offer_take) begin
      watchdog <= WD_W'(TIMEOUT_CYCLES - 1);
    end else if (state == WAIT_ARRIVE && watchdog != '0) begin
      watchdog <= watchdog - 1'b1;
    end
  end

  assign wd_done = (watchdog == '0);
`else
  assign wd_done = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (pending != '0) state_nxt = OFFER;
      OFFER: begin
        // Call served elsewhere before acceptance: withdraw the offer.
        if (!tgt_pending)    state_nxt = IDLE;
        else if (offer_take) state_nxt = WAIT_ARRIVE;
      end
      WAIT_ARRIVE: begin
        // On watchdog expiry pending[req_floor] is still set, so the
        // target gets offered again from IDLE.
        if (arrived)      state_nxt = IDLE;
        else if (wd_done) state_nxt = IDLE;
      end
      default:            state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req.req_valid = (state == OFFER) && tgt_pending;
    timeout       = (state == WAIT_ARRIVE) && !arrived && wd_done;
  end

  assign req.req_floor = req_floor_r;

endmodule

// File: tb/tb_elevator_call_panel.sv
// Self-checking bench for elevator_call_panel: directed vector table,
// hand-written multi-cycle sequences (handshake stall, reset with held
// button, async reset mid-offer, watchdog when REQ_TIMEOUT_EN is defined)
// and a randomized run against a distance-based reference model.
module tb_elevator_call_panel;
  localparam int NF = 5;
  localparam int TO = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn;
  logic [2:0] car_floor;
  logic       car_stopped;
  logic [4:0] pending;
  logic       dir_up;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  elevator_call_panel_if bus();

  elevator_call_panel #(.NUM_FLOORS(NF), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .car_floor  (car_floor),
    .car_stopped(car_stopped),
    .req        (bus.master),
    .pending    (pending),
    .dir_up     (dir_up),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "bench time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input logic [4:0] ep, input logic ev,
                            input logic [2:0] ef, input logic ed);
    check({tag, "_pending"}, 32'(pending), 32'(ep));
    check({tag, "_valid"},   32'(bus.req_valid), 32'(ev));
    check({tag, "_floor"},   32'(bus.req_floor), 32'(ef));
    check({tag, "_dir"},     32'(dir_up), 32'(ed));
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_OFFER, M_WAIT} mph_t;
  bit   m_pend[NF];
  bit   m_btnq[NF];
  bit   m_armed;
  bit   m_up;
  int   m_tgt;
  int   m_wcnt;
  mph_t m_phase;

  task automatic model_reset();
    for (int f = 0; f < NF; f++) begin
      m_pend[f] = 1'b0;
      m_btnq[f] = 1'b0;
    end
    m_armed = 1'b0;
    m_up    = 1'b1;
    m_tgt   = 0;
    m_wcnt  = 0;
    m_phase = M_IDLE;
  endtask

  // Closest pending floor strictly ahead of the car in the given direction.
  function automatic int nearest(input bit up);
    int best_d = 1000;
    int best_f = -1;
    int d;
    for (int f = 0; f < NF; f++) begin
      if (m_pend[f]) begin
        d = up ? (f - int'(car_floor)) : (int'(car_floor) - f);
        if (d > 0 && d < best_d) begin
          best_d = d;
          best_f = f;
        end
      end
    end
    return best_f;
  endfunction

  function automatic bit model_any();
    bit a = 1'b0;
    for (int f = 0; f < NF; f++) a |= m_pend[f];
    return a;
  endfunction

  function automatic logic [4:0] model_pend_vec();
    logic [4:0] v;
    for (int f = 0; f < NF; f++) v[f] = m_pend[f];
    return v;
  endfunction

  task automatic model_step();
    int  n;
    bit  arrived_m;
    arrived_m = car_stopped && (int'(car_floor) == m_tgt);
    case (m_phase)
      M_IDLE: if (model_any()) begin
        if (int'(car_floor) < NF && m_pend[car_floor]) begin
          m_tgt = int'(car_floor);
        end else begin
          n = nearest(m_up);
          if (n < 0) begin
            m_up = !m_up;
            n    = nearest(m_up);
          end
          m_tgt = n;
        end
        m_phase = M_OFFER;
      end
      M_OFFER: begin
        if (!m_pend[m_tgt]) m_phase = M_IDLE;
        else if (bus.req_ready) begin
          m_phase = M_WAIT;
          m_wcnt  = 1;
        end
      end
      M_WAIT: begin
        if (arrived_m) m_phase = M_IDLE;
`ifdef REQ_TIMEOUT_EN
        else if (m_wcnt == TO) m_phase = M_IDLE;
        else m_wcnt++;
`endif
      end
      default: m_phase = M_IDLE;
    endcase
    for (int f = 0; f < NF; f++) begin
      if (car_stopped && int'(car_floor) == f) m_pend[f] = 1'b0;
      else if (m_armed && btn[f] && !m_btnq[f]) m_pend[f] = 1'b1;
      m_btnq[f] = btn[f];
    end
    m_armed = 1'b1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [4:0] btn;
    logic [2:0] cf;
    logic       st;
    logic       rdy;
    logic [4:0] ep;
    logic       ev;
    logic [2:0] ef;
    logic       ed;
  } vec_t;

  vec_t tbl [22];

  initial begin
    logic [4:0] exp_p;
    logic       exp_v;
    logic       exp_t;
    int         found;

    tbl[0]  = '{5'b00000, 3'd0, 1'b0, 1'b0, 5'b00000, 1'b0, 3'd0, 1'b1};
    tbl[1]  = '{5'b01000, 3'd0, 1'b0, 1'b0, 5'b01000, 1'b0, 3'd0, 1'b1};
    tbl[2]  = '{5'b00000, 3'd0, 1'b0, 1'b0, 5'b01000, 1'b1, 3'd3, 1'b1};
    tbl[3]  = '{5'b00000, 3'd0, 1'b0, 1'b0, 5'b01000, 1'b1, 3'd3, 1'b1};
    tbl[4]  = '{5'b00000, 3'd0, 1'b0, 1'b1, 5'b01000, 1'b0, 3'd3, 1'b1};
    tbl[5]  = '{5'b00000, 3'd3, 1'b0, 1'b0, 5'b01000, 1'b0, 3'd3, 1'b1};
    tbl[6]  = '{5'b00000, 3'd3, 1'b1, 1'b0, 5'b00000, 1'b0, 3'd3, 1'b1};
    tbl[7]  = '{5'b00000, 3'd3, 1'b0, 1'b0, 5'b00000, 1'b0, 3'd3, 1'b1};
    tbl[8]  = '{5'b10001, 3'd2, 1'b0, 1'b0, 5'b10001, 1'b0, 3'd3, 1'b1};
    tbl[9]  = '{5'b00000, 3'd2, 1'b0, 1'b0, 5'b10001, 1'b1, 3'd4, 1'b1};
    tbl[10] = '{5'b00000, 3'd2, 1'b0, 1'b1, 5'b10001, 1'b0, 3'd4, 1'b1};
    tbl[11] = '{5'b00000, 3'd4, 1'b1, 1'b0, 5'b00001, 1'b0, 3'd4, 1'b1};
    tbl[12] = '{5'b00000, 3'd4, 1'b1, 1'b0, 5'b00001, 1'b1, 3'd0, 1'b0};
    tbl[13] = '{5'b00000, 3'd4, 1'b0, 1'b0, 5'b00001, 1'b1, 3'd0, 1'b0};
    tbl[14] = '{5'b00000, 3'd0, 1'b1, 1'b0, 5'b00000, 1'b0, 3'd0, 1'b0};
    tbl[15] = '{5'b00000, 3'd0, 1'b0, 1'b0, 5'b00000, 1'b0, 3'd0, 1'b0};
    tbl[16] = '{5'b00100, 3'd2, 1'b1, 1'b0, 5'b00000, 1'b0, 3'd0, 1'b0};
    tbl[17] = '{5'b00000, 3'd2, 1'b0, 1'b0, 5'b00000, 1'b0, 3'd0, 1'b0};
    tbl[18] = '{5'b00010, 3'd0, 1'b0, 1'b0, 5'b00010, 1'b0, 3'd0, 1'b0};
    tbl[19] = '{5'b00010, 3'd1, 1'b1, 1'b0, 5'b00000, 1'b0, 3'd1, 1'b0};
    tbl[20] = '{5'b00010, 3'd1, 1'b0, 1'b0, 5'b00000, 1'b0, 3'd1, 1'b0};
    tbl[21] = '{5'b00000, 3'd1, 1'b0, 1'b0, 5'b00000, 1'b0, 3'd1, 1'b0};

    reset         = 1'b1;
    btn           = '0;
    car_floor     = '0;
    car_stopped   = 1'b0;
    bus.req_ready = 1'b0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_outs("reset", 5'b00000, 1'b0, 3'd0, 1'b1);
    reset = 1'b1;

    // Table: inputs applied at negedge, outputs checked one clock later.
    for (int i = 0; i < 22; i++) begin
      btn           = tbl[i].btn;
      car_floor     = tbl[i].cf;
      car_stopped   = tbl[i].st;
      bus.req_ready = tbl[i].rdy;
      tick();
      check_outs($sformatf("row%0d", i), tbl[i].ep, tbl[i].ev, tbl[i].ef, tbl[i].ed);
    end

    // Stalled handshake: floor must hold while ready stays low.
    btn = 5'b01000;
    tick();
    btn = 5'b00000;
    tick();
    check_outs("stall_start", 5'b01000, 1'b1, 3'd3, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("stall%0d_valid", i), 32'(bus.req_valid), 32'd1);
      check($sformatf("stall%0d_floor", i), 32'(bus.req_floor), 32'd3);
    end
    bus.req_ready = 1'b1;
    tick();
    check_outs("stall_accept", 5'b01000, 1'b0, 3'd3, 1'b1);
    bus.req_ready = 1'b0;
    car_floor     = 3'd3;
    car_stopped   = 1'b1;
    tick();
    check_outs("stall_arrive", 5'b00000, 1'b0, 3'd3, 1'b1);
    car_stopped = 1'b0;
    tick();

    // Button held through reset must not register until re-pressed.
    btn   = 5'b00010;
    reset = 1'b0;
    #1;
    check_outs("hold_rst", 5'b00000, 1'b0, 3'd0, 1'b1);
    @(negedge clk);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold%0d_pending", i), 32'(pending), 32'd0);
    end
    btn = 5'b00000;
    tick();
    check("hold_release_pending", 32'(pending), 32'd0);
    btn = 5'b00010;
    tick();
    check("hold_repress_pending", 32'(pending), 32'b00010);
    btn = 5'b00000;
    tick();
    check_outs("repress_offer", 5'b00010, 1'b1, 3'd1, 1'b0);

    // Asynchronous reset in the middle of an offer.
    #2 reset = 1'b0;
    #1;
    check_outs("async_rst", 5'b00000, 1'b0, 3'd0, 1'b1);
    @(negedge clk);
    reset = 1'b1;

`ifdef REQ_TIMEOUT_EN
    car_floor   = 3'd0;
    car_stopped = 1'b0;
    tick();
    btn = 5'b10000;
    tick();
    btn = 5'b00000;
    tick();
    check("wd_offer_floor", 32'(bus.req_floor), 32'd4);
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    found = -1;
    for (int n = 1; n <= 400; n++) begin
      if (timeout) begin
        found = n;
        break;
      end
      tick();
    end
    check("wd_pulse_clock", 32'(found), 32'd255);
    tick();
    check("wd_after_timeout", 32'(timeout), 32'd0);
    check("wd_idle_valid", 32'(bus.req_valid), 32'd0);
    tick();
    check("wd_reoffer_valid", 32'(bus.req_valid), 32'd1);
    check("wd_reoffer_floor", 32'(bus.req_floor), 32'd4);
    check("wd_reoffer_pending", 32'(pending), 32'b10000);
`endif

    // Randomized run against the reference model.
    btn           = '0;
    car_stopped   = 1'b0;
    bus.req_ready = 1'b0;
    reset         = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int f = 0; f < NF; f++)
        if ($urandom_range(0, 7) == 0) btn[f] = ~btn[f];
      car_floor     = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                                  : 3'($urandom_range(0, 4));
      car_stopped   = ($urandom_range(0, 3) == 0);
      bus.req_ready = ($urandom_range(0, 1) == 1);
      #1;
      exp_p = model_pend_vec();
      exp_v = (m_phase == M_OFFER) && m_pend[m_tgt];
      exp_t = 1'b0;
`ifdef REQ_TIMEOUT_EN
      exp_t = (m_phase == M_WAIT) && (m_wcnt == TO) &&
              !(car_stopped && int'(car_floor) == m_tgt);
`endif
      check($sformatf("rnd%0d_pending", c), 32'(pending), 32'(exp_p));
      check($sformatf("rnd%0d_valid", c),   32'(bus.req_valid), 32'(exp_v));
      check($sformatf("rnd%0d_floor", c),   32'(bus.req_floor), 32'(m_tgt));
      check($sformatf("rnd%0d_dir", c),     32'(dir_up), 32'(m_up));
      check($sformatf("rnd%0d_timeout", c), 32'(timeout), 32'(exp_t));
      model_step();
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/elevator_call_panel.md
ELEVATOR_CALL_PANEL -- requirements
Module: elevator_call_panel

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 5, number of served floors (fixed at 5 in this release).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, watchdog limit in clocks (used only under REQ_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port btn  input  5  level call buttons; bit i = floor i.
REQ-006 SHALL have port car_floor  input  3  current car floor, binary 0-4.
REQ-007 SHALL have port car_stopped  input  1  car stopped at car_floor with doors open.
REQ-008 SHALL have port req_ready  input  1  elevator accepts the offered target.
REQ-009 SHALL have port req_valid  output  1  target floor offered.
REQ-010 SHALL have port req_floor  output  3  target floor, binary.
REQ-011 SHALL have port pending  output  5  latched outstanding calls (lamp drive).
REQ-012 SHALL have port dir_up  output  1  current sweep direction, 1 = up.
REQ-013 SHALL have port timeout  output  1  one-cycle watchdog pulse (tied 0 without REQ_TIMEOUT_EN).

Function
REQ-014 SHALL register btn into btn_q each clock and set pending[i] on btn[i] & ~btn_q[i]; pending visible the clock after the rising edge is sampled; held buttons set only once.
REQ-015 SHALL clear pending[car_floor] on every clock with car_stopped=1 and car_floor<=4; car_floor>4 clears nothing.
REQ-016 SHALL give clear priority over set when both target the same bit in the same clock.
REQ-017 SHALL implement states IDLE, OFFER, WAIT_ARRIVE.
REQ-018 IDLE: if pending!=0, SHALL select target, register req_floor, go to OFFER; else stay.
REQ-019 Selection SHALL be: pending[car_floor] -> car_floor; else if dir_up, lowest pending above car_floor; else if !dir_up, highest pending below car_floor; if none in current direction, SHALL toggle dir_up and select nearest pending in the opposite direction in the same clock.
REQ-020 OFFER: req_valid=1, req_floor stable; transfer on clock where req_valid & req_ready; then go to WAIT_ARRIVE.
REQ-021 OFFER: if pending[req_floor] is cleared before transfer, SHALL drop req_valid and return to IDLE next clock.
REQ-022 WAIT_ARRIVE: on car_stopped=1 with car_floor==req_floor SHALL return to IDLE; no re-targeting while waiting.
REQ-023 req_valid SHALL be 0 in IDLE and WAIT_ARRIVE; req_floor holds its last value.
REQ-024 Minimum latency btn edge sampled -> req_valid high SHALL be 2 clocks.

Reset
REQ-025 On reset=0, SHALL asynchronously force state=IDLE, btn_q=0, pending=0, req_valid=0, req_floor=0, dir_up=1, timeout=0, watchdog=0.
REQ-026 Reset mid-OFFER or mid-WAIT_ARRIVE SHALL discard all calls; buttons still held at release SHALL NOT re-register until released and pressed again (btn_q reloaded from btn on first clock after release, not setting pending).

Configuration
REQ-027 With REQ_TIMEOUT_EN defined, SHALL count clocks in WAIT_ARRIVE; reaching TIMEOUT_CYCLES SHALL return to IDLE, pulse timeout for one clock, and keep pending[req_floor] set for re-offer.
REQ-028 Without REQ_TIMEOUT_EN, SHALL contain no watchdog counter; timeout tied 0; WAIT_ARRIVE waits indefinitely.

Verification
REQ-029 Reset release, car_floor=0, pulse btn[3] -> pending=01000, req_valid high 2 clocks later with req_floor=3, dir_up=1.
REQ-030 car_floor=2, dir_up=1, pending=10001 -> req_floor=4; after arrival at 4, req_floor=0 and dir_up=0.
REQ-031 req_valid high, req_ready held 0 for 10 clocks -> req_floor stable all 10; ready=1 -> WAIT_ARRIVE, req_valid=0 next clock.
REQ-032 btn[2] edge same clock as car_stopped=1, car_floor=2 -> pending[2] remains 0.
REQ-033 Hold btn[1] across reset deassertion -> pending stays 00000 until btn[1] released and re-pressed.
REQ-034 REQ_TIMEOUT_EN, TIMEOUT_CYCLES=255, accept req_floor=4, never stop -> timeout pulses at 255th WAIT_ARRIVE clock, req_valid re-asserts with req_floor=4.
